// File: rtl/cc_micro_pkg.sv
// Shared types, field-position helpers and decode-address builder for the
// cc_micro_sequencer control unit.
package cc_micro_pkg;

   typedef enum logic [2:0] {
      COND_NEXT   = 3'b000,
      COND_N      = 3'b001,
      COND_Z      = 3'b010,
      COND_V      = 3'b011,
      COND_C      = 3'b100,
      COND_IR13   = 3'b101,
      COND_JUMP   = 3'b110,
      COND_DECODE = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_WAIT,
      S_HALT
   } state_e;

   localparam int unsigned COND_W = 3;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned REG_W  = 6;

   // Field LSB positions; everything above JADDR sits at a fixed offset from aw.
   function automatic int unsigned cond_lsb(int unsigned aw);
      return aw;
   endfunction

   function automatic int unsigned alu_lsb(int unsigned aw);
      return aw + 3;
   endfunction

   function automatic int unsigned wr_bit(int unsigned aw);
      return aw + 7;
   endfunction

   function automatic int unsigned rd_bit(int unsigned aw);
      return aw + 8;
   endfunction

   function automatic int unsigned c_lsb(int unsigned aw);
      return aw + 10;
   endfunction

   function automatic int unsigned b_lsb(int unsigned aw);
      return aw + 17;
   endfunction

   function automatic int unsigned a_lsb(int unsigned aw);
      return aw + 24;
   endfunction

   // Top nine bits of the opcode-dispatch address; callers pad with zeros below.
   function automatic logic [8:0] decode_prefix(logic [31:0] ir);
      return {1'b1, ir[31:30], ir[24:19]};
   endfunction

endpackage

// File: rtl/cc_micro_sequencer_next_addr.sv
// Combinational next-microaddress selector driven by COND, ALU flags and IR.
module cc_micro_next_addr
   import cc_micro_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 11
) (
   input  cond_e                 cond,
   input  logic [ADDR_WIDTH-1:0] jaddr,
   input  logic [ADDR_WIDTH-1:0] upc,
   input  logic [3:0]            flags,
   input  logic [31:0]           ir,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   localparam int unsigned PAD = ADDR_WIDTH - 9;

   logic [ADDR_WIDTH-1:0] upc_inc;
   logic [ADDR_WIDTH-1:0] decode_addr;

   assign upc_inc     = upc + ADDR_WIDTH'(1);
   assign decode_addr = ADDR_WIDTH'(decode_prefix(ir)) << PAD;

   always_comb begin
      next_addr = upc_inc;
      case (cond)
         COND_NEXT:   next_addr = upc_inc;
         COND_N:      next_addr = flags[3] ? jaddr : upc_inc;
         COND_Z:      next_addr = flags[2] ? jaddr : upc_inc;
         COND_V:      next_addr = flags[1] ? jaddr : upc_inc;
         COND_C:      next_addr = flags[0] ? jaddr : upc_inc;
         COND_IR13:   next_addr = ir[13]   ? jaddr : upc_inc;
         COND_JUMP:   next_addr = jaddr;
         COND_DECODE: next_addr = decode_addr;
         default:     next_addr = upc_inc;
      endcase
   end

endmodule

// File: rtl/cc_micro_sequencer.sv
// Writable control store and microsequencer FSM; drives the datapath microword
// each cycle, stalls on memory handshakes and halts on an all-zero word.
module cc_micro_sequencer
   import cc_micro_pkg::*;
#(
   parameter  int unsigned ADDR_WIDTH = 11,
   localparam int unsigned WORD_WIDTH = 30 + ADDR_WIDTH
) (
   input  logic                  CC_MICRO_SEQUENCER_CLOCK_50,
   input  logic                  CC_MICRO_SEQUENCER_RESET_InLow,
   input  logic                  CC_MICRO_SEQUENCER_load_valid_InLow,
   input  logic [ADDR_WIDTH-1:0] CC_MICRO_SEQUENCER_load_addr_InBUS,
   input  logic [WORD_WIDTH-1:0] CC_MICRO_SEQUENCER_load_data_InBUS,
   input  logic                  CC_MICRO_SEQUENCER_start_InLow,
   input  logic [3:0]            CC_MICRO_SEQUENCER_flags_InBUS,
   input  logic [31:0]           CC_MICRO_SEQUENCER_ir_InBUS,
   input  logic                  CC_MICRO_SEQUENCER_mem_ready_InLow,
   output logic [WORD_WIDTH-1:0] CC_MICRO_SEQUENCER_microword_OutBUS,
   output logic [ADDR_WIDTH-1:0] CC_MICRO_SEQUENCER_upc_OutBUS,
   output logic                  CC_MICRO_SEQUENCER_stall_OutHigh,
   output logic                  CC_MICRO_SEQUENCER_halt_OutHigh
);

   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam int unsigned COND_LSB  = cond_lsb(ADDR_WIDTH);
   localparam int unsigned RD_BIT    = rd_bit(ADDR_WIDTH);
   localparam int unsigned WR_BIT    = wr_bit(ADDR_WIDTH);

   logic                  clk;
   logic                  rst_n;
   logic [WORD_WIDTH-1:0] store [DEPTH];
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] upc_q, upc_d;
   logic [WORD_WIDTH-1:0] raw_word;
   logic [WORD_WIDTH-1:0] mw;
   logic                  active;
   logic                  mem_access;
   logic [ADDR_WIDTH-1:0] next_addr;

   assign clk   = CC_MICRO_SEQUENCER_CLOCK_50;
   assign rst_n = CC_MICRO_SEQUENCER_RESET_InLow;

   // Store contents are deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && !CC_MICRO_SEQUENCER_load_valid_InLow)
         store[CC_MICRO_SEQUENCER_load_addr_InBUS] <= CC_MICRO_SEQUENCER_load_data_InBUS;
   end

   assign raw_word   = store[upc_q];
   assign active     = (state_q == S_RUN) || (state_q == S_WAIT);
   assign mw         = active ? raw_word : '0;
   assign mem_access = mw[RD_BIT] | mw[WR_BIT];

   cc_micro_next_addr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_next_addr (
      .cond      (cond_e'(mw[COND_LSB +: COND_W])),
      .jaddr     (mw[ADDR_WIDTH-1:0]),
      .upc       (upc_q),
      .flags     (CC_MICRO_SEQUENCER_flags_InBUS),
      .ir        (CC_MICRO_SEQUENCER_ir_InBUS),
      .next_addr (next_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         upc_q   <= '0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      upc_d   = upc_q;
      case (state_q)
         S_IDLE: begin
            if (!CC_MICRO_SEQUENCER_start_InLow) begin
               state_d = S_RUN;
               upc_d   = '0;
            end
         end
         S_RUN: begin
            if (mw == '0)
               state_d = S_HALT;
            else if (mem_access && CC_MICRO_SEQUENCER_mem_ready_InLow)
               state_d = S_WAIT;
            else
               upc_d = next_addr;
         end
         S_WAIT: begin
            if (!CC_MICRO_SEQUENCER_mem_ready_InLow) begin
               state_d = S_RUN;
               upc_d   = next_addr;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
            upc_d   = '0;
         end
      endcase
   end

   assign CC_MICRO_SEQUENCER_microword_OutBUS = mw;
   assign CC_MICRO_SEQUENCER_upc_OutBUS       = upc_q;
   assign CC_MICRO_SEQUENCER_stall_OutHigh    = (state_q == S_WAIT);
   assign CC_MICRO_SEQUENCER_halt_OutHigh     = (state_q == S_HALT);

endmodule

// File: tb/tb_cc_micro_sequencer.sv
// Directed scoreboard bench for cc_micro_sequencer.
module tb_cc_micro_sequencer;

   localparam int unsigned AW = 11;
   localparam int unsigned WW = 30 + AW;

   logic          clk;
   logic          rst_n;
   logic          load_valid_n;
   logic [AW-1:0] load_addr;
   logic [WW-1:0] load_data;
   logic          start_n;
   logic [3:0]    flags;
   logic [31:0]   ir;
   logic          ready_n;
   logic [WW-1:0] mw;
   logic [AW-1:0] upc;
   logic          stall;
   logic          halt;

   typedef struct {
      string         tag;
      logic [AW-1:0] upc;
      logic          stall;
      logic          halt;
      logic [WW-1:0] mw;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   cc_micro_sequencer #(.ADDR_WIDTH(AW)) dut (
      .CC_MICRO_SEQUENCER_CLOCK_50         (clk),
      .CC_MICRO_SEQUENCER_RESET_InLow      (rst_n),
      .CC_MICRO_SEQUENCER_load_valid_InLow (load_valid_n),
      .CC_MICRO_SEQUENCER_load_addr_InBUS  (load_addr),
      .CC_MICRO_SEQUENCER_load_data_InBUS  (load_data),
      .CC_MICRO_SEQUENCER_start_InLow      (start_n),
      .CC_MICRO_SEQUENCER_flags_InBUS      (flags),
      .CC_MICRO_SEQUENCER_ir_InBUS         (ir),
      .CC_MICRO_SEQUENCER_mem_ready_InLow  (ready_n),
      .CC_MICRO_SEQUENCER_microword_OutBUS (mw),
      .CC_MICRO_SEQUENCER_upc_OutBUS       (upc),
      .CC_MICRO_SEQUENCER_stall_OutHigh    (stall),
      .CC_MICRO_SEQUENCER_halt_OutHigh     (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Microword from field values, positions taken from the field layout (W=41).
   function automatic logic [WW-1:0] mk(logic [3:0] alu, logic rd, logic wr,
                                        logic [2:0] cond, logic [AW-1:0] jaddr);
      logic [WW-1:0] w;
      w         = '0;
      w[40:35]  = 6'd1;
      w[19]     = rd;
      w[18]     = wr;
      w[17:14]  = alu;
      w[13:11]  = cond;
      w[10:0]   = jaddr;
      return w;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(string tag, logic [AW-1:0] u, logic s, logic h, logic [WW-1:0] w);
      exp_t e;
      e.tag = tag; e.upc = u; e.stall = s; e.halt = h; e.mw = w;
      sb.push_back(e);
   endtask

   // Compare n queued expectations, one per cycle, starting at the current sample point.
   task automatic drain(int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
            return;
         end
         e = sb.pop_front();
         chk({e.tag, "_upc"},   64'(upc),   64'(e.upc));
         chk({e.tag, "_stall"}, 64'(stall), 64'(e.stall));
         chk({e.tag, "_halt"},  64'(halt),  64'(e.halt));
         chk({e.tag, "_mw"},    64'(mw),    64'(e.mw));
         @(posedge clk); #1;
      end
   endtask

   task automatic load(logic [AW-1:0] a, logic [WW-1:0] d);
      load_valid_n = 1'b0; load_addr = a; load_data = d;
      @(posedge clk); #1;
      load_valid_n = 1'b1;
   endtask

   task automatic start_pulse();
      start_n = 1'b0;
      @(posedge clk); #1;
      start_n = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   logic [WW-1:0] w0, w1, w2, w12, w0z, w0d, w0r, w0j;

   initial begin
      load_valid_n = 1'b1; load_addr = '0; load_data = '0;
      start_n = 1'b1; flags = 4'b0; ir = 32'b0; ready_n = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("rst_upc", 64'(upc), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_mw", 64'(mw), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: straight-line then unconditional jump back to 0
      w0 = mk(4'd1, 1'b0, 1'b0, 3'b000, 11'd0);
      w1 = mk(4'd2, 1'b0, 1'b0, 3'b000, 11'd0);
      w2 = mk(4'd3, 1'b0, 1'b0, 3'b110, 11'd0);
      load(11'd0, w0); load(11'd1, w1); load(11'd2, w2);
      push("t1_c0", 11'd0, 1'b0, 1'b0, w0);
      push("t1_c1", 11'd1, 1'b0, 1'b0, w1);
      push("t1_c2", 11'd2, 1'b0, 1'b0, w2);
      push("t1_c3", 11'd0, 1'b0, 1'b0, w0);
      push("t1_c4", 11'd1, 1'b0, 1'b0, w1);
      start_pulse();
      drain(5);

      // 2: branch on z; load and start in the same cycle
      do_reset();
      w12 = mk(4'd5, 1'b0, 1'b0, 3'b000, 11'd0);
      w0z = mk(4'd4, 1'b0, 1'b0, 3'b010, 11'd12);
      load(11'd12, w12);
      flags = 4'b0100;
      push("t2z_c0", 11'd0, 1'b0, 1'b0, w0z);
      push("t2z_c1", 11'd12, 1'b0, 1'b0, w12);
      load_valid_n = 1'b0; load_addr = 11'd0; load_data = w0z; start_n = 1'b0;
      @(posedge clk); #1;
      load_valid_n = 1'b1; start_n = 1'b1;
      drain(2);
      do_reset();
      flags = 4'b1011;
      push("t2nz_c0", 11'd0, 1'b0, 1'b0, w0z);
      push("t2nz_c1", 11'd1, 1'b0, 1'b0, w1);
      start_pulse();
      drain(2);

      // 3: opcode decode dispatch
      do_reset();
      w0d = mk(4'd6, 1'b0, 1'b0, 3'b111, 11'd7);
      load(11'd0, w0d);
      ir = 32'h8080_0000;
      start_pulse();
      chk("t3_upc0", 64'(upc), 64'd0);
      @(posedge clk); #1;
      chk("t3_decode", 64'(upc), 64'd1600);
      ir = 32'b0;

      // 4: memory read stalls three cycles
      do_reset();
      w0r = mk(4'd1, 1'b1, 1'b0, 3'b000, 11'd0);
      load(11'd0, w0r);
      ready_n = 1'b1;
      push("t4_run", 11'd0, 1'b0, 1'b0, w0r);
      push("t4_w1",  11'd0, 1'b1, 1'b0, w0r);
      push("t4_w2",  11'd0, 1'b1, 1'b0, w0r);
      start_pulse();
      drain(3);
      ready_n = 1'b0;
      push("t4_w3",  11'd0, 1'b1, 1'b0, w0r);
      push("t4_go",  11'd1, 1'b0, 1'b0, w1);
      drain(2);
      // ready already low: no wait state at all
      do_reset();
      push("t4n_c0", 11'd0, 1'b0, 1'b0, w0r);
      push("t4n_c1", 11'd1, 1'b0, 1'b0, w1);
      start_pulse();
      drain(2);

      // 5: jump into an empty word halts
      do_reset();
      w0j = mk(4'd1, 1'b0, 1'b0, 3'b110, 11'd5);
      load(11'd5, '0);
      load(11'd0, w0j);
      push("t5_c0", 11'd0, 1'b0, 1'b0, w0j);
      push("t5_c1", 11'd5, 1'b0, 1'b0, '0);
      push("t5_h0", 11'd5, 1'b0, 1'b1, '0);
      start_pulse();
      drain(3);
      start_n = 1'b0;
      push("t5_h1", 11'd5, 1'b0, 1'b1, '0);
      push("t5_h2", 11'd5, 1'b0, 1'b1, '0);
      drain(2);
      start_n = 1'b1;
      do_reset();
      chk("t5_rst_upc", 64'(upc), 64'd0);
      chk("t5_rst_halt", 64'(halt), 64'd0);

      // 6: async reset in WAIT, then replay without reloading
      load(11'd0, w0r);
      ready_n = 1'b1;
      push("t6_run", 11'd0, 1'b0, 1'b0, w0r);
      push("t6_w",   11'd0, 1'b1, 1'b0, w0r);
      start_pulse();
      drain(2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_stall", 64'(stall), 64'd0);
      chk("t6_rst_upc", 64'(upc), 64'd0);
      chk("t6_rst_mw", 64'(mw), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_n = 1'b0;
      push("t6_r0", 11'd0, 1'b0, 1'b0, w0r);
      push("t6_r1", 11'd1, 1'b0, 1'b0, w1);
      push("t6_r2", 11'd2, 1'b0, 1'b0, w2);
      push("t6_r3", 11'd0, 1'b0, 1'b0, w0r);
      start_pulse();
      drain(4);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
